// File: rtl/rob_multi_if.sv
`default_nettype none
// ============================================================================
// Module      : rob_multi_if
// Description : Dispatch / completion / commit bundle for the rob_multi
//               reorder buffer. Flush_IN exists only with ROB_FLUSH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
interface rob_multi_if #(
    parameter int SIZE         = 64,
    parameter int LA           = 5,
    parameter int LP           = 7,
    parameter int COMMIT_WIDTH = 2
);
    localparam int c_LT = $clog2(SIZE);

    logic                         Entry_valid_IN;
    logic [LA-1:0]                Entry_arch_IN;
    logic [LP-1:0]                Entry_phys_IN;
    logic [LP-1:0]                Entry_oldphys_IN;
    logic                         Entry_regwrite_IN;
    logic [c_LT-1:0]              Alloc_tag;
    logic                         Full;
    logic                         Empty;
    logic                         Complete_valid_IN;
    logic [c_LT-1:0]              Complete_tag_IN;
    logic [COMMIT_WIDTH-1:0]      Commit_valid;
    logic [COMMIT_WIDTH*LA-1:0]   Commit_arch;
    logic [COMMIT_WIDTH*LP-1:0]   Commit_phys;
    logic [COMMIT_WIDTH*LP-1:0]   Commit_oldphys;
    logic [COMMIT_WIDTH-1:0]      Commit_regwrite;
`ifdef ROB_FLUSH_EN
    logic                         Flush_IN;
`endif

    modport master (
`ifdef ROB_FLUSH_EN
        output Flush_IN,
`endif
        output Entry_valid_IN, Entry_arch_IN, Entry_phys_IN, Entry_oldphys_IN,
        output Entry_regwrite_IN, Complete_valid_IN, Complete_tag_IN,
        input  Alloc_tag, Full, Empty, Commit_valid, Commit_arch,
        input  Commit_phys, Commit_oldphys, Commit_regwrite
    );

    modport slave (
`ifdef ROB_FLUSH_EN
        input  Flush_IN,
`endif
        input  Entry_valid_IN, Entry_arch_IN, Entry_phys_IN, Entry_oldphys_IN,
        input  Entry_regwrite_IN, Complete_valid_IN, Complete_tag_IN,
        output Alloc_tag, Full, Empty, Commit_valid, Commit_arch,
        output Commit_phys, Commit_oldphys, Commit_regwrite
    );
endinterface
`default_nettype wire

// File: rtl/rob_multi.sv
`default_nettype none
// ============================================================================
// Module      : rob_multi
// Description : Reorder buffer, one dispatch per cycle, tag-based completion,
//               up to COMMIT_WIDTH in-order retirements per cycle.
//               Optional synchronous flush enabled by macro ROB_FLUSH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`ifndef PROJ_NUM_ARCH_REGS
`define PROJ_NUM_ARCH_REGS 32
`endif
`ifndef PROJ_NUM_PHYS_REGS
`define PROJ_NUM_PHYS_REGS 128
`endif

module rob_multi #(
    parameter int SIZE          = 64,
    parameter int NUM_ARCH_REGS = `PROJ_NUM_ARCH_REGS,
    parameter int NUM_PHYS_REGS = `PROJ_NUM_PHYS_REGS,
    parameter int COMMIT_WIDTH  = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    rob_multi_if.slave  bus
);
    localparam int              c_LT       = $clog2(SIZE);
    localparam int              c_LA       = $clog2(NUM_ARCH_REGS);
    localparam int              c_LP       = $clog2(NUM_PHYS_REGS);
    localparam int              c_NW       = $clog2(COMMIT_WIDTH + 1);
    localparam logic [c_LT:0]   c_SIZE_CNT = (c_LT+1)'(SIZE);

    logic [c_LA-1:0]    r_arch    [SIZE];
    logic [c_LP-1:0]    r_phys    [SIZE];
    logic [c_LP-1:0]    r_oldphys [SIZE];
    logic [SIZE-1:0]    r_regwrite;
    logic [SIZE-1:0]    r_valid;
    logic [SIZE-1:0]    r_done;
    logic [c_LT-1:0]    r_head;
    logic [c_LT-1:0]    r_tail;
    logic [c_LT:0]      r_count;

    logic                       w_flush;
    logic                       w_full;
    logic                       w_accept;
    logic [c_LT-1:0]            w_slot [COMMIT_WIDTH];
    logic [COMMIT_WIDTH-1:0]    w_commit_valid;
    logic [c_NW-1:0]            w_ncommit;
    logic                       w_run;

`ifdef ROB_FLUSH_EN
    assign w_flush = bus.Flush_IN;
`else
    assign w_flush = 1'b0;
`endif

    assign w_full        = (r_count == c_SIZE_CNT);
    assign w_accept      = bus.Entry_valid_IN & ~w_full & ~w_flush;
    assign bus.Full      = w_full;
    assign bus.Empty     = (r_count == '0);
    assign bus.Alloc_tag = r_tail;

    // Slot indices wrap naturally through the pointer width.
    generate
        for (genvar gi = 0; gi < COMMIT_WIDTH; gi++) begin : g_slot
            assign w_slot[gi]                         = r_head + c_LT'(gi);
            assign bus.Commit_arch[gi*c_LA +: c_LA]   = r_arch[w_slot[gi]];
            assign bus.Commit_phys[gi*c_LP +: c_LP]   = r_phys[w_slot[gi]];
            assign bus.Commit_oldphys[gi*c_LP +: c_LP] = r_oldphys[w_slot[gi]];
            assign bus.Commit_regwrite[gi]            = r_regwrite[w_slot[gi]];
        end
    endgenerate

    // Contiguous prefix: the first non-retirable slot blocks all younger ones.
    always_comb begin
        w_commit_valid = '0;
        w_ncommit      = '0;
        w_run          = ~w_flush;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            w_run = w_run & r_valid[w_slot[i]] & r_done[w_slot[i]]
                  & ((c_LT+1)'(i) < r_count);
            w_commit_valid[i] = w_run;
            if (w_run) begin
                w_ncommit = w_ncommit + 1'b1;
            end
        end
    end

    assign bus.Commit_valid = w_commit_valid;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_valid <= '0;
            r_done  <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_valid <= '0;
            r_done  <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (bus.Complete_valid_IN && r_valid[bus.Complete_tag_IN]) begin
                r_done[bus.Complete_tag_IN] <= 1'b1;
            end
            // Retirement clears override a same-cycle completion of that slot.
            for (int i = 0; i < COMMIT_WIDTH; i++) begin
                if (w_commit_valid[i]) begin
                    r_valid[w_slot[i]] <= 1'b0;
                    r_done[w_slot[i]]  <= 1'b0;
                end
            end
            if (w_accept) begin
                r_valid[r_tail] <= 1'b1;
                r_done[r_tail]  <= 1'b0;
            end
            r_head  <= r_head + c_LT'(w_ncommit);
            r_tail  <= r_tail + c_LT'(w_accept);
            r_count <= r_count + (c_LT+1)'(w_accept) - (c_LT+1)'(w_ncommit);
        end
    end

    // Payload is only meaningful while the valid bit is set, so it needs no reset.
    always_ff @(posedge CLK) begin
        if (w_accept) begin
            r_arch[r_tail]     <= bus.Entry_arch_IN;
            r_phys[r_tail]     <= bus.Entry_phys_IN;
            r_oldphys[r_tail]  <= bus.Entry_oldphys_IN;
            r_regwrite[r_tail] <= bus.Entry_regwrite_IN;
        end
    end

endmodule
`default_nettype wire
